// File: rtl/player_pkg.sv
// Shared types and helpers for the per-character player controller.
//   player_state_t : movement state, exposed on the controller's state port
//   vel_t          : 10-bit signed velocity
//   psum_t         : 11-bit signed position sum (position + velocity)
//   pos_add        : unsigned 10-bit position plus signed velocity
//   clamp_pos      : limits a position sum to [lo, hi] and narrows it to 10 bits
package player_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        JUMP = 2'd2,
        FALL = 2'd3
    } player_state_t;

    typedef logic signed [9:0]  vel_t;
    typedef logic signed [10:0] psum_t;

    // One extra bit keeps a 0..1023 position plus a negative velocity
    // representable, so that underflow shows up as a negative sum.
    function automatic psum_t pos_add(input logic [9:0] p, input vel_t v);
        return $signed({1'b0, p}) + $signed({v[9], v});
    endfunction

    function automatic logic [9:0] clamp_pos(input psum_t v, input psum_t lo, input psum_t hi);
        if (v < lo) return lo[9:0];
        if (v > hi) return hi[9:0];
        return v[9:0];
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Turns the asynchronous vsync-rate frame_clk level into a single-Clk tick.
//   Clk       : system clock
//   Reset_n   : asynchronous active-low reset
//   frame_clk : asynchronous frame strobe (level)
//   tick      : registered one-cycle pulse per frame_clk rising edge
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic tick
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    // Two flops resolve metastability, the third holds the previous
    // synchronised level for the rising-edge compare.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
            tick      <= 1'b0;
        end else begin
            sync_1    <= frame_clk;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            tick      <= sync_2 & ~sync_prev;
        end
    end

endmodule

// File: rtl/player_controller.sv
// Per-character controller: horizontal motion, jump/fall physics, facing,
// animation frame counter and sprite ROM addressing.
//   Clk, Reset_n         : system clock, asynchronous active-low reset
//   frame_clk            : asynchronous frame strobe; physics runs once per rising edge
//   revive               : synchronous respawn to the start position
//   key_left/right/jump  : decoded key levels
//   DrawX, DrawY         : pixel currently being drawn
//   pos_x, pos_y         : sprite top-left corner
//   state                : IDLE=0, RUN=1, JUMP=2, FALL=3
//   facing_left          : sprite is mirrored horizontally when set
//   frame_index          : current animation frame
//   is_player            : DrawX/DrawY falls inside the sprite box
//   sprite_addr          : sprite ROM address (0 outside the box)
module player_controller
    import player_pkg::*;
#(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 48,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 479,
    parameter int START_X     = 32,
    parameter int START_Y     = 416,
    parameter int VEL_X       = 2,
    parameter int JUMP_VEL    = 12,
    parameter int GRAVITY     = 1,
    parameter int MAX_FALL    = 8,
    parameter int FRAME_COUNT = 3,
    parameter int ANIM_DIV    = 4,
    parameter int ADDR_W      = 11
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_clk,
    input  logic              revive,
    input  logic              key_left,
    input  logic              key_right,
    input  logic              key_jump,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [9:0]        pos_x,
    output logic [9:0]        pos_y,
    output logic [1:0]        state,
    output logic              facing_left,
    output logic [1:0]        frame_index,
    output logic              is_player,
    output logic [ADDR_W-1:0] sprite_addr
);

    localparam psum_t X_LO    = psum_t'(X_MIN);
    localparam psum_t X_HI    = psum_t'(X_MAX + 1 - SPR_W);
    localparam psum_t Y_LO    = psum_t'(Y_MIN);
    localparam psum_t FLOOR_S = psum_t'(Y_MAX + 1 - SPR_H);

    localparam logic [9:0] FLOOR_P   = 10'(Y_MAX + 1 - SPR_H);
    localparam logic [9:0] START_X_P = 10'(START_X);
    localparam logic [9:0] START_Y_P = 10'(START_Y);
    localparam logic [9:0] Y_MIN_P   = 10'(Y_MIN);

    localparam vel_t VX_POS = vel_t'(VEL_X);
    localparam vel_t VX_NEG = vel_t'(-VEL_X);
    localparam vel_t JV_NEG = vel_t'(-JUMP_VEL);
    localparam vel_t GRAV_V = vel_t'(GRAVITY);
    localparam vel_t MAXF_V = vel_t'(MAX_FALL);

    localparam logic [7:0] DIV_LAST = 8'(ANIM_DIV - 1);
    localparam logic [1:0] FC_LAST  = 2'(FRAME_COUNT - 1);

    localparam logic [9:0]        SPR_W_P  = 10'(SPR_W);
    localparam logic [9:0]        SPR_H_P  = 10'(SPR_H);
    localparam logic [9:0]        SPR_W_M1 = 10'(SPR_W - 1);
    localparam logic [ADDR_W-1:0] SPR_W_A  = ADDR_W'(SPR_W);

    logic tick;

    frame_tick_gen u_tick (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // Registered state
    logic [9:0]    pos_x_r;
    logic [9:0]    pos_y_r;
    vel_t          vx;
    vel_t          vy;
    player_state_t st;
    logic          face_r;
    logic [1:0]    frame_r;
    logic [7:0]    anim_cnt;

    // Next-tick values
    vel_t          vx_new;
    vel_t          vy_p1;
    vel_t          vy_fall;
    psum_t         y_sum;
    player_state_t run_st;
    player_state_t nst;
    logic [9:0]    nx;
    logic [9:0]    ny;
    vel_t          nvy;
    logic          nface;

    always_comb begin
        vx_new = '0;
        if (key_left && !key_right)
            vx_new = VX_NEG;
        else if (key_right && !key_left)
            vx_new = VX_POS;

        nface = face_r;
        if (key_left && !key_right)
            nface = 1'b1;
        else if (key_right && !key_left)
            nface = 1'b0;

        run_st  = (vx_new != '0) ? RUN : IDLE;
        vy_p1   = vy + GRAV_V;
        vy_fall = (vy_p1 > MAXF_V) ? MAXF_V : vy_p1;

        nx    = clamp_pos(pos_add(pos_x_r, vx_new), X_LO, X_HI);
        ny    = pos_y_r;
        nvy   = vy;
        nst   = st;
        y_sum = '0;

        case (st)
            IDLE, RUN: begin
                if (key_jump) begin
                    // Launch moves by the full jump velocity on the same tick.
                    nst   = JUMP;
                    nvy   = JV_NEG;
                    y_sum = pos_add(pos_y_r, JV_NEG);
                    ny    = clamp_pos(y_sum, Y_LO, FLOOR_S);
                end else if (pos_y_r != FLOOR_P) begin
                    nst = FALL;
                    nvy = '0;
                end else begin
                    nst = run_st;
                end
            end
            JUMP: begin
                nvy   = vy_p1;
                y_sum = pos_add(pos_y_r, vy_p1);
                if (y_sum <= Y_LO) begin
                    // Head hit the ceiling: stop and start falling from rest.
                    ny  = Y_MIN_P;
                    nvy = '0;
                    nst = FALL;
                end else begin
                    ny = y_sum[9:0];
                    if (!vy_p1[9])
                        nst = FALL;
                end
            end
            FALL: begin
                nvy   = vy_fall;
                y_sum = pos_add(pos_y_r, vy_fall);
                if (y_sum >= FLOOR_S) begin
                    ny  = FLOOR_P;
                    nvy = '0;
                    nst = run_st;
                end else begin
                    ny = y_sum[9:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pos_x_r  <= START_X_P;
            pos_y_r  <= START_Y_P;
            vx       <= '0;
            vy       <= '0;
            st       <= IDLE;
            face_r   <= 1'b0;
            frame_r  <= '0;
            anim_cnt <= '0;
        end else if (revive) begin
            pos_x_r  <= START_X_P;
            pos_y_r  <= START_Y_P;
            vx       <= '0;
            vy       <= '0;
            st       <= IDLE;
            face_r   <= 1'b0;
            frame_r  <= '0;
            anim_cnt <= '0;
        end else if (tick) begin
            pos_x_r <= nx;
            pos_y_r <= ny;
            vx      <= vx_new;
            vy      <= nvy;
            st      <= nst;
            face_r  <= nface;
            // A new state always starts its animation from frame 0.
            if (nst != st) begin
                anim_cnt <= '0;
                frame_r  <= '0;
            end else if (anim_cnt == DIV_LAST) begin
                anim_cnt <= '0;
                frame_r  <= (frame_r == FC_LAST) ? 2'd0 : frame_r + 2'd1;
            end else begin
                anim_cnt <= anim_cnt + 8'd1;
            end
        end
    end

    // Pixel side. Offsets are unsigned, so pixels left of or above the
    // sprite wrap to large values and fail the bounds test.
    logic [9:0]        ox;
    logic [9:0]        oy;
    logic [9:0]        col;
    logic [ADDR_W-1:0] addr_full;

    always_comb begin
        ox        = DrawX - pos_x_r;
        oy        = DrawY - pos_y_r;
        is_player = (ox < SPR_W_P) && (oy < SPR_H_P);
        col       = face_r ? (SPR_W_M1 - ox) : ox;
        addr_full = ADDR_W'(oy) * SPR_W_A + ADDR_W'(col);
        sprite_addr = is_player ? addr_full : '0;
    end

    assign pos_x       = pos_x_r;
    assign pos_y       = pos_y_r;
    assign state       = st;
    assign facing_left = face_r;
    assign frame_index = frame_r;

endmodule

// File: tb/tb_player_controller.sv
module tb_player_controller;

  localparam int START_X = 32;
  localparam int START_Y = 416;
  localparam int FLOOR   = 432;
  localparam int X_RIGHT = 608;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_JUMP  = 2;
  localparam int S_FALL  = 3;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic frame_clk = 1'b0;
  logic revive = 1'b0;
  logic key_left = 1'b0;
  logic key_right = 1'b0;
  logic key_jump = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;

  logic [9:0]  pos_x, pos_y;
  logic [1:0]  state;
  logic        facing_left;
  logic [1:0]  frame_index;
  logic        is_player;
  logic [10:0] sprite_addr;

  logic [9:0]  c_pos_x, c_pos_y;
  logic [1:0]  c_state;
  logic        c_facing_left;
  logic [1:0]  c_frame_index;
  logic        c_is_player;
  logic [10:0] c_sprite_addr;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state (plain integers)
  int m_x, m_y, m_vy, m_st, m_face, m_frame, m_cnt;

  player_controller dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .revive(revive),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
    .DrawX(DrawX), .DrawY(DrawY),
    .pos_x(pos_x), .pos_y(pos_y), .state(state), .facing_left(facing_left),
    .frame_index(frame_index), .is_player(is_player), .sprite_addr(sprite_addr)
  );

  player_controller #(.START_Y(20)) dut_c (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .revive(revive),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
    .DrawX(DrawX), .DrawY(DrawY),
    .pos_x(c_pos_x), .pos_y(c_pos_y), .state(c_state), .facing_left(c_facing_left),
    .frame_index(c_frame_index), .is_player(c_is_player), .sprite_addr(c_sprite_addr)
  );

  // Clock / reset
  always #5 Clk = ~Clk;

  task automatic model_reset();
    m_x = START_X; m_y = START_Y; m_vy = 0; m_st = S_IDLE;
    m_face = 0; m_frame = 0; m_cnt = 0;
  endtask

  task automatic model_tick(input bit l, input bit r, input bit j);
    int vx;
    int old_st;
    vx = (l && !r) ? -2 : ((r && !l) ? 2 : 0);
    if (l && !r) m_face = 1;
    if (r && !l) m_face = 0;
    m_x = m_x + vx;
    if (m_x < 0) m_x = 0;
    if (m_x > X_RIGHT) m_x = X_RIGHT;
    old_st = m_st;
    if (m_st == S_IDLE || m_st == S_RUN) begin
      if (j) begin
        m_st = S_JUMP; m_vy = -12; m_y = m_y - 12;
        if (m_y < 0) m_y = 0;
      end else if (m_y != FLOOR) begin
        m_st = S_FALL; m_vy = 0;
      end else begin
        m_st = (vx != 0) ? S_RUN : S_IDLE;
      end
    end else if (m_st == S_JUMP) begin
      m_vy = m_vy + 1;
      m_y = m_y + m_vy;
      if (m_y <= 0) begin
        m_y = 0; m_vy = 0; m_st = S_FALL;
      end else if (m_vy >= 0) begin
        m_st = S_FALL;
      end
    end else begin
      m_vy = (m_vy + 1 > 8) ? 8 : m_vy + 1;
      m_y = m_y + m_vy;
      if (m_y >= FLOOR) begin
        m_y = FLOOR; m_vy = 0; m_st = (vx != 0) ? S_RUN : S_IDLE;
      end
    end
    if (m_st != old_st) begin
      m_cnt = 0; m_frame = 0;
    end else if (m_cnt == 3) begin
      m_cnt = 0; m_frame = (m_frame + 1) % 3;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  // Driver: one frame_clk period with the given keys held, then advance the model.
  task automatic do_tick(input bit l, input bit r, input bit j);
    key_left = l; key_right = r; key_jump = j;
    frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    model_tick(l, r, j);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    n_checks++;
    if (pos_x !== 10'(START_X) || pos_y !== 10'(START_Y) || state !== 2'(S_IDLE) ||
        facing_left !== 1'b0 || frame_index !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_values: got x=%0d y=%0d st=%0d f=%0b fr=%0d want x=32 y=416 st=0 f=0 fr=0",
               pos_x, pos_y, state, facing_left, frame_index);
    end
    do_tick(1'b0, 1'b0, 1'b1);
    repeat (3) do_tick(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (pos_y !== 10'(m_y) || state !== 2'(m_st)) begin
      n_errors++;
      $display("FAIL mid_jump: got y=%0d st=%0d want y=%0d st=%0d", pos_y, state, m_y, m_st);
    end
    Reset_n = 1'b0;
    #2;
    n_checks++;
    if (pos_x !== 10'(START_X) || pos_y !== 10'(START_Y) || state !== 2'(S_IDLE) || frame_index !== 2'd0) begin
      n_errors++;
      $display("FAIL async_reset: got x=%0d y=%0d st=%0d fr=%0d want x=32 y=416 st=0 fr=0",
               pos_x, pos_y, state, frame_index);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_revive();
    repeat (3) do_tick(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (pos_x !== 10'(m_x) || pos_y !== 10'(m_y) || state !== 2'(m_st)) begin
      n_errors++;
      $display("FAIL pre_revive: got x=%0d y=%0d st=%0d want x=%0d y=%0d st=%0d",
               pos_x, pos_y, state, m_x, m_y, m_st);
    end
    // revive held across a whole frame pulse, so it coincides with the tick
    revive = 1'b1; key_right = 1'b1;
    frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    revive = 1'b0;
    model_reset();
    n_checks++;
    if (pos_x !== 10'(START_X) || pos_y !== 10'(START_Y) || state !== 2'(S_IDLE) ||
        facing_left !== 1'b0 || frame_index !== 2'd0) begin
      n_errors++;
      $display("FAIL revive_tick: got x=%0d y=%0d st=%0d f=%0b fr=%0d want x=32 y=416 st=0 f=0 fr=0",
               pos_x, pos_y, state, facing_left, frame_index);
    end
  endtask

  task automatic test_run_clamp();
    for (int t = 0; t < 300; t++) begin
      do_tick(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (pos_x !== 10'(m_x) || pos_y !== 10'(m_y) || state !== 2'(m_st) ||
          facing_left !== 1'(m_face) || frame_index !== 2'(m_frame)) begin
        n_errors++;
        $display("FAIL run_tick %0d: got x=%0d y=%0d st=%0d f=%0b fr=%0d want x=%0d y=%0d st=%0d f=%0d fr=%0d",
                 t, pos_x, pos_y, state, facing_left, frame_index, m_x, m_y, m_st, m_face, m_frame);
      end
    end
    n_checks++;
    if (pos_x !== 10'(X_RIGHT) || state !== 2'(S_RUN)) begin
      n_errors++;
      $display("FAIL wall_clamp: got x=%0d st=%0d want x=608 st=1", pos_x, state);
    end
    do_tick(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (state !== 2'(S_IDLE) || pos_x !== 10'(X_RIGHT)) begin
      n_errors++;
      $display("FAIL release_idle: got x=%0d st=%0d want x=608 st=0", pos_x, state);
    end
  endtask

  task automatic test_jump_arc();
    int min_y;
    bit landed;
    min_y = 1023;
    landed = 0;
    do_tick(1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 60 && !landed; t++) begin
      if (int'(pos_y) < min_y) min_y = int'(pos_y);
      do_tick(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (pos_x !== 10'(m_x) || pos_y !== 10'(m_y) || state !== 2'(m_st) || frame_index !== 2'(m_frame)) begin
        n_errors++;
        $display("FAIL arc_tick %0d: got y=%0d st=%0d fr=%0d want y=%0d st=%0d fr=%0d",
                 t, pos_y, state, frame_index, m_y, m_st, m_frame);
      end
      if (state == 2'(S_IDLE)) landed = 1;
    end
    n_checks++;
    if (min_y != FLOOR - 78) begin
      n_errors++;
      $display("FAIL jump_apex: got y=%0d want y=%0d", min_y, FLOOR - 78);
    end
    n_checks++;
    if (!landed || pos_y !== 10'(FLOOR) || state !== 2'(S_IDLE)) begin
      n_errors++;
      $display("FAIL jump_land: got y=%0d st=%0d landed=%0d want y=432 st=0 landed=1", pos_y, state, landed);
    end
  endtask

  task automatic test_both_keys();
    do_tick(1'b1, 1'b0, 1'b0);
    do_tick(1'b1, 1'b1, 1'b0);
    do_tick(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (facing_left !== 1'b1 || state !== 2'(S_IDLE) || pos_x !== 10'(m_x)) begin
      n_errors++;
      $display("FAIL both_keys_left: got x=%0d st=%0d f=%0b want x=%0d st=0 f=1", pos_x, state, facing_left, m_x);
    end
    do_tick(1'b0, 1'b1, 1'b0);
    do_tick(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (facing_left !== 1'b0 || state !== 2'(S_IDLE) || pos_x !== 10'(m_x)) begin
      n_errors++;
      $display("FAIL both_keys_right: got x=%0d st=%0d f=%0b want x=%0d st=0 f=0", pos_x, state, facing_left, m_x);
    end
    do_tick(1'b1, 1'b0, 1'b0);
    DrawX = 10'(m_x); DrawY = 10'(m_y);
    #1;
    n_checks++;
    if (facing_left !== 1'b1 || is_player !== 1'b1 || sprite_addr !== 11'd31) begin
      n_errors++;
      $display("FAIL mirror_origin: got f=%0b hit=%0b addr=%0d want f=1 hit=1 addr=31", facing_left, is_player, sprite_addr);
    end
    DrawX = 10'(m_x + 31); DrawY = 10'(m_y + 47);
    #1;
    n_checks++;
    if (is_player !== 1'b1 || sprite_addr !== 11'd1504) begin
      n_errors++;
      $display("FAIL mirror_corner: got hit=%0b addr=%0d want hit=1 addr=1504", is_player, sprite_addr);
    end
    DrawX = 10'(m_x - 1); DrawY = 10'(m_y);
    #1;
    n_checks++;
    if (is_player !== 1'b0 || sprite_addr !== 11'd0) begin
      n_errors++;
      $display("FAIL left_of_sprite: got hit=%0b addr=%0d want hit=0 addr=0", is_player, sprite_addr);
    end
  endtask

  task automatic test_anim();
    do_tick(1'b0, 1'b1, 1'b0);
    do_tick(1'b0, 1'b0, 1'b0);
    for (int t = 1; t <= 12; t++) begin
      do_tick(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (frame_index !== 2'(m_frame) || state !== 2'(m_st)) begin
        n_errors++;
        $display("FAIL anim_tick %0d: got fr=%0d st=%0d want fr=%0d st=%0d", t, frame_index, state, m_frame, m_st);
      end
      if (t % 4 == 0) begin
        n_checks++;
        if (frame_index !== 2'((t / 4) % 3)) begin
          n_errors++;
          $display("FAIL anim_step %0d: got fr=%0d want fr=%0d", t, frame_index, (t / 4) % 3);
        end
      end
    end
    do_tick(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (state !== 2'(S_RUN) || frame_index !== 2'd0) begin
      n_errors++;
      $display("FAIL anim_state_change: got st=%0d fr=%0d want st=1 fr=0", state, frame_index);
    end
    DrawX = 10'(m_x - 1); DrawY = 10'(m_y + 5);
    #1;
    n_checks++;
    if (is_player !== 1'b0) begin
      n_errors++;
      $display("FAIL anim_left_pixel: got hit=%0b want hit=0", is_player);
    end
  endtask

  task automatic test_random();
    bit l, r, j;
    int offx, offy, dx, dy, exp_hit, exp_addr;
    for (int t = 0; t < 250; t++) begin
      l = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      j = ($urandom_range(0, 7) == 0);
      do_tick(l, r, j);
      n_checks++;
      if (pos_x !== 10'(m_x) || pos_y !== 10'(m_y) || state !== 2'(m_st) ||
          facing_left !== 1'(m_face) || frame_index !== 2'(m_frame)) begin
        n_errors++;
        $display("FAIL rand_tick %0d: got x=%0d y=%0d st=%0d f=%0b fr=%0d want x=%0d y=%0d st=%0d f=%0d fr=%0d",
                 t, pos_x, pos_y, state, facing_left, frame_index, m_x, m_y, m_st, m_face, m_frame);
      end
      offx = int'($urandom_range(0, 40)) - 4;
      offy = int'($urandom_range(0, 56)) - 4;
      dx = (m_x + offx) & 1023;
      dy = (m_y + offy) & 1023;
      DrawX = 10'(dx); DrawY = 10'(dy);
      #1;
      exp_hit = (dx >= m_x && dx < m_x + 32 && dy >= m_y && dy < m_y + 48) ? 1 : 0;
      exp_addr = exp_hit ? (dy - m_y) * 32 + (m_face ? 31 - (dx - m_x) : dx - m_x) : 0;
      n_checks++;
      if (is_player !== 1'(exp_hit) || sprite_addr !== 11'(exp_addr)) begin
        n_errors++;
        $display("FAIL rand_pixel %0d: got hit=%0b addr=%0d want hit=%0d addr=%0d (dx=%0d dy=%0d)",
                 t, is_player, sprite_addr, exp_hit, exp_addr, dx, dy);
      end
    end
  endtask

  task automatic test_ceiling();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    do_tick(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (c_pos_y !== 10'd8 || c_state !== 2'(S_JUMP)) begin
      n_errors++;
      $display("FAIL ceil_launch: got y=%0d st=%0d want y=8 st=2", c_pos_y, c_state);
    end
    do_tick(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (c_pos_y !== 10'd0 || c_state !== 2'(S_FALL)) begin
      n_errors++;
      $display("FAIL ceil_clamp: got y=%0d st=%0d want y=0 st=3", c_pos_y, c_state);
    end
    do_tick(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (c_pos_y !== 10'd1 || c_state !== 2'(S_FALL)) begin
      n_errors++;
      $display("FAIL ceil_vy_zero: got y=%0d st=%0d want y=1 st=3", c_pos_y, c_state);
    end
  endtask

  initial begin
    test_reset();
    test_revive();
    test_run_clamp();
    test_jump_arc();
    test_both_keys();
    test_anim();
    test_random();
    test_ceiling();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
